// File: rtl/seq_mult_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_shift_add
// Purpose  : Sequential shift-and-add multiplier with signed/unsigned mode,
//            one partial product per clock, start/ready/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_p;

  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_acc_sum;

  // The most negative operand negates to itself, which read as unsigned is
  // exactly its magnitude, so plain negation is sufficient here.
  assign w_mag_a   = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b   = (is_signed && b[WIDTH-1]) ? -b : b;
  assign w_addend  = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
  assign w_acc_sum = r_mplier[0] ? (r_acc + w_addend) : r_acc;
  assign p         = r_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == c_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_p      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_CALC: begin
          r_acc    <= w_acc_sum;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + c_CNT_W'(1);
          if (r_cnt == c_LAST) begin
            r_p <= r_neg ? -w_acc_sum : w_acc_sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
